serial_rb_sub: RTL and testbench



---
 rtl/serial_rb_sub.sv | 162 ++++++++++++++++
 tb/tb_serial_rb_sub.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_rb_sub.sv
// -----------------------------------------------------------------------------
// serial_rb_sub
// Bit-serial ripple-borrow subtractor. Computes DIFF = A - B - BIN one bit per
// clock, LSB first, through a single full-subtractor cell and a registered
// borrow. The operation is framed by a start/busy/done handshake.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, accepted only in IDLE or DONE
//   A, B   : minuend / subtrahend, captured on the accepting edge
//   BIN    : borrow-in, captured on the accepting edge
//   busy   : high while the subtraction is running
//   done   : one-cycle pulse, results valid from this cycle on
//   DIFF   : A - B - BIN modulo 2^WIDTH (held until the next commit)
//   BOUT   : borrow-out, 1 when unsigned A < B + BIN
//   OVF    : two's-complement overflow of the subtraction
// -----------------------------------------------------------------------------
module serial_rb_sub #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             BOUT,
    output logic             OVF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    // Full-subtractor borrow-out.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~a & bi) | (b & bi);
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   sa_r;
    logic [WIDTH-1:0]   sb_r;
    // Only WIDTH-1 result bits need storage: the last bit goes straight into DIFF.
    logic [WIDTH-2:0]   sd_r;
    logic               br_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               a_msb_r;
    logic               b_msb_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   diff_r;
    logic               bout_r;
    logic               ovf_r;

    logic               d_s;
    logic               br_next_s;
    logic [WIDTH-1:0]   sd_shift_s;
    logic               last_s;

    // Full-subtractor cell on the operand LSBs and the result shift path.
    always_comb begin
        d_s        = 1'b0;
        br_next_s  = 1'b0;
        sd_shift_s = {WIDTH{1'b0}};
        last_s     = 1'b0;
        if (state_r == RUN) begin
            d_s        = fs_diff(sa_r[0], sb_r[0], br_r);
            br_next_s  = fs_borrow(sa_r[0], sb_r[0], br_r);
            sd_shift_s = {d_s, sd_r};
            last_s     = (cnt_r == CNT_W'(WIDTH - 1));
        end else begin
            d_s        = 1'b0;
            br_next_s  = 1'b0;
            sd_shift_s = {WIDTH{1'b0}};
            last_s     = 1'b0;
        end
    end

    // Control FSM, datapath shift registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sa_r    <= {WIDTH{1'b0}};
            sb_r    <= {WIDTH{1'b0}};
            sd_r    <= {(WIDTH-1){1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        sa_r    <= A;
                        sb_r    <= B;
                        br_r    <= BIN;
                        sd_r    <= {(WIDTH-1){1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        a_msb_r <= A[WIDTH-1];
                        b_msb_r <= B[WIDTH-1];
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    sa_r <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r <= {1'b0, sb_r[WIDTH-1:1]};
                    sd_r <= sd_shift_s[WIDTH-1:1];
                    br_r <= br_next_s;
                    if (last_s) begin
                        // Commit: the last difference bit is the result MSB.
                        diff_r  <= sd_shift_s;
                        bout_r  <= br_next_s;
                        ovf_r   <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign DIFF = diff_r;
    assign BOUT = bout_r;
    assign OVF  = ovf_r;

endmodule

// File: tb/tb_serial_rb_sub.sv
// Directed bench for serial_rb_sub at WIDTH=4 and WIDTH=8.
module tb_serial_rb_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start4 = 1'b0;
    logic [3:0] a4 = 4'd0;
    logic [3:0] b4 = 4'd0;
    logic       bin4 = 1'b0;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] diff4;

    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'd0;
    logic [7:0] b8 = 8'd0;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_rb_sub #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .BIN(bin4),
        .busy(busy4), .done(done4), .DIFF(diff4), .BOUT(bout4), .OVF(ovf4)
    );

    serial_rb_sub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .BIN(bin8),
        .busy(busy8), .done(done8), .DIFF(diff8), .BOUT(bout8), .OVF(ovf8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Wait (bounded) for done4, returning the number of negedges waited.
    task automatic wait_done4(output int n);
        n = 0;
        while (done4 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Full 4-bit operation with latency and result checks.
    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic bin, input logic [3:0] ed, input logic eb, input logic eo);
        int n;
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 4'hx; b4 = 4'hx; bin4 = 1'bx;
        chk({tag, "_busy"}, 32'(busy4), 32'd1);
        wait_done4(n);
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_diff"}, 32'(diff4), 32'(ed));
        chk({tag, "_bout"}, 32'(bout4), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf4), 32'(eo));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done4), 32'd0);
        a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk({tag, "_busy"}, 32'(busy8), 32'd1);
        wait_done8(n);
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_diff"}, 32'(diff8), 32'(ed));
        chk({tag, "_bout"}, 32'(bout8), 32'(eb));
        chk({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_diff", 32'(diff4), 32'd0);
        chk("rst_bout8", 32'(bout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 4-bit vectors (OVF values follow the flag definition)
        op4("sub9_3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
        op4("sub3_9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
        op4("sub8_1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
        op4("sub0_0b", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        op4("sub0_Fb", 4'd0, 4'hF, 1'b1, 4'd0, 1'b1, 1'b0);
        op4("subeq", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);

        // Handshake: start during busy ignored, back-to-back from DONE
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(n);
        chk("hs_done", 32'(done4), 32'd1);
        chk("hs_diff", 32'(diff4), 32'd3);
        a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("hs_b2b_busy", 32'(busy4), 32'd1);
        chk("hs_b2b_done", 32'(done4), 32'd0);
        chk("hs_hold", 32'(diff4), 32'd3);
        @(negedge clk);
        chk("hs_hold2", 32'(diff4), 32'd3);
        wait_done4(n);
        chk("hs_b2b_lat", 32'(n), 32'd3);
        chk("hs_b2b_diff", 32'(diff4), 32'd0);

        // Reset mid-RUN after a nonzero result
        op4("pre_rst", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy4), 32'd0);
        chk("arst_diff", 32'(diff4), 32'd0);
        chk("arst_bout", 32'(bout4), 32'd0);
        chk("arst_ovf", 32'(ovf4), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("arst_nodone", 32'(done4), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_nodone", 32'(done4), 32'd0);
        chk("post_rst_diff", 32'(diff4), 32'd0);
        op4("sub6_4", 4'd6, 4'd4, 1'b0, 4'd2, 1'b0, 1'b0);

        // 8-bit instance
        op8("w8_0_1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op8("w8_80_1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
